// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode constants, width defaults and
// the issuer FSM state encoding.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CTRL_W_DEF = 4;
    localparam int unsigned CNT_W      = 4;

    localparam logic [3:0] ALU_NOT  = 4'b0100;
    localparam logic [3:0] ALU_IDLE = 4'b1101;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StResp  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_result_chk.sv
// Result checker: compares the sampled ALU output with the expected value captured at
// command accept and keeps a saturating count of mismatching responses.
module alu_result_chk #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [DATA_W-1:0] cmd_exp,
    input  logic              sample,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              rsp_hs,
    output logic              rsp_mismatch,
    output logic [7:0]        err_cnt
);

    logic [DATA_W-1:0] exp_q, exp_d;
    logic              mismatch_q, mismatch_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    always_comb begin
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;
        if (accept) begin
            exp_d = cmd_exp;
        end
        if (sample) begin
            mismatch_d = (alu_out != exp_q);
        end
        if (rsp_hs && mismatch_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rsp_mismatch = mismatch_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Transactional initiator for the combinational ALU: accepts a command, holds the ALU
// inputs for SETTLE cycles, samples out/carry and returns them. ALU_CHECK_EN adds checking.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned          DATA_W    = DATA_W_DEF,
    parameter int unsigned          CTRL_W    = CTRL_W_DEF,
    parameter int unsigned          SETTLE    = 1,
    parameter logic [CTRL_W-1:0]    IDLE_CTRL = ALU_IDLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CTRL_W-1:0] cmd_ctrl,
    input  logic [DATA_W-1:0] cmd_x,
    input  logic [DATA_W-1:0] cmd_y,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CTRL_W-1:0] rsp_ctrl,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_carry,
`ifdef ALU_CHECK_EN
    input  logic [DATA_W-1:0] cmd_exp,
    output logic              rsp_mismatch,
    output logic [7:0]        err_cnt,
`endif
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] alu_x_q, alu_x_d;
    logic [DATA_W-1:0] alu_y_q, alu_y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CTRL_W-1:0] rsp_ctrl_q, rsp_ctrl_d;
    logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
    logic              rsp_carry_q, rsp_carry_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ctrl_d  = rsp_ctrl_q;
        rsp_out_d   = rsp_out_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_ctrl_d = cmd_ctrl;
                    alu_x_d    = cmd_x;
                    alu_y_d    = cmd_y;
                    cnt_d      = CNT_W'(SETTLE - 1);
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_out_d   = alu_out;
                    rsp_carry_d = alu_carry;
                    rsp_ctrl_d  = alu_ctrl_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    alu_ctrl_d  = IDLE_CTRL;
                    alu_x_d     = '0;
                    alu_y_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Status flags are registered from the next state so they line up with it.
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            alu_ctrl_q  <= IDLE_CTRL;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ctrl_q  <= '0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ctrl_q  <= rsp_ctrl_d;
            rsp_out_q   <= rsp_out_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ctrl  = rsp_ctrl_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_carry = rsp_carry_q;

`ifdef ALU_CHECK_EN
    logic chk_accept, chk_sample, chk_rsp_hs;

    assign chk_accept = (state_q == StIdle) && cmd_valid && cmd_ready_q;
    assign chk_sample = (state_q == StDrive) && (cnt_q == '0);
    assign chk_rsp_hs = (state_q == StResp) && rsp_valid_q && rsp_ready;

    alu_result_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .accept       (chk_accept),
        .cmd_exp      (cmd_exp),
        .sample       (chk_sample),
        .alu_out      (alu_out),
        .rsp_hs       (chk_rsp_hs),
        .rsp_mismatch (rsp_mismatch),
        .err_cnt      (err_cnt)
    );
`endif

endmodule
